// File: rtl/vga_stream_gen.sv
// vga_stream_gen: free-running VGA timing source producing a registered
// 23-bit pixel stream {XC, YC, HS, VS, Active}, a one-cycle end-of-visible-
// frame strobe and an 8-bit completed-frame counter.
module vga_stream_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic        en,
    output logic [22:0] VGAStr_o,
    output logic        endframe,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Sync windows end one past the last sync pixel/line, which can reach
    // 1024, so those bounds are compared at 11 bits.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]  H_EF     = 10'(H_VISIBLE - 1);
    localparam logic [9:0]  V_EF     = 10'(V_VISIBLE - 1);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    // Counters are 10 bits wide; larger timings cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_stream_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [9:0] x_cnt;
    logic [9:0] y_cnt;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       frame_wrap;
    logic       hs_on;
    logic       vs_on;
    logic       active_on;
    logic       endframe_on;

    // Next counter position; the frame wraps when both counters roll over.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        x_next     = x_cnt + 10'd1;
        y_next     = y_cnt;
        frame_wrap = 1'b0;
        if (x_cnt == H_LAST) begin
            x_next = '0;
            y_next = y_cnt + 10'd1;
            if (y_cnt == V_LAST) begin
                y_next     = '0;
                frame_wrap = 1'b1;
            end
        end
    end

    // Stream fields decoded from the current counter position.
    always_comb begin
        hs_on       = ({1'b0, x_cnt} >= HS_START) && ({1'b0, x_cnt} < HS_END);
        vs_on       = ({1'b0, y_cnt} >= VS_START) && ({1'b0, y_cnt} < VS_END);
        active_on   = (x_cnt < H_VIS) && (y_cnt < V_VIS);
        endframe_on = (x_cnt == H_EF) && (y_cnt == V_EF);
    end

    // Counter and output registers; reset wins over en, en=0 freezes all.
    always_ff @(posedge px_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and the outputs stay coherent.
        if (reset) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            VGAStr_o  <= {10'd0, 10'd0, ~HS_POL, ~VS_POL, 1'b0};
            endframe  <= 1'b0;
            frame_cnt <= '0;
        end else if (en) begin
            x_cnt     <= x_next;
            y_cnt     <= y_next;
            VGAStr_o  <= {x_cnt, y_cnt,
                          hs_on ? HS_POL : ~HS_POL,
                          vs_on ? VS_POL : ~VS_POL,
                          active_on};
            endframe  <= endframe_on;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
